mem_verify_reader: RTL and testbench

// - Read-back checker for the on-board memory demo: the reading end opposite the pattern-writing FSM.
// - Sweeps a contiguous address window through the memory's synchronous read port.
// - Compares every returned word against the deterministic pattern the writer stores.
// - Reports pass/fail, mismatch count and first failing address for 7-seg/LED display.

---
 rtl/mem_demo_pkg.sv | 24 ++
 rtl/mem_err_tracker.sv | 38 +++
 rtl/mem_verify_reader.sv | 121 ++++++++++++
 tb/tb_mem_verify_reader.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/mem_demo_pkg.sv
// Shared definitions for the on-board memory demo (pattern writer and read-back checker).
//   ADDR_W_DEF / DATA_W_DEF : default memory geometry
//   state_t                 : reader sweep states
//   expected_word()         : deterministic pattern stored at each address; the writer
//                             and the reader both call it so the two cannot diverge
package mem_demo_pkg;

    localparam int unsigned ADDR_W_DEF = 10;
    localparam int unsigned DATA_W_DEF = 16;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SCAN  = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    // Pattern = zero-extended address XOR seed; callers truncate to their data width.
    function automatic logic [31:0] expected_word(input logic [31:0] addr,
                                                  input logic [31:0] seed);
        return addr ^ seed;
    endfunction

endpackage

// File: rtl/mem_err_tracker.sv
// Mismatch bookkeeping for the read-back checker.
//   clk, reset_n   : clock, async active-low reset
//   clear          : start of a new sweep, zeroes both results
//   cmp_valid      : a compare is being retired this cycle
//   cmp_addr       : address of the word being compared
//   mismatch       : the compared word differed from the pattern
//   err_count      : mismatches seen in the last/current sweep
//   first_err_addr : address of the first mismatch, 0 if none
module mem_err_tracker #(
    parameter int unsigned ADDR_W = 10
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              clear,
    input  logic              cmp_valid,
    input  logic [ADDR_W-1:0] cmp_addr,
    input  logic              mismatch,
    output logic [ADDR_W:0]   err_count,
    output logic [ADDR_W-1:0] first_err_addr
);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            err_count      <= '0;
            first_err_addr <= '0;
        end else if (clear) begin
            err_count      <= '0;
            first_err_addr <= '0;
        end else if (cmp_valid && mismatch) begin
            // At most 2^ADDR_W compares per sweep, so ADDR_W+1 bits never overflow.
            err_count <= err_count + (ADDR_W+1)'(1);
            if (err_count == '0) begin
                first_err_addr <= cmp_addr;
            end
        end
    end

endmodule

// File: rtl/mem_verify_reader.sv
// Read-back checker: sweeps BASE..BASE+DEPTH-1 (mod 2^ADDR_W) through a synchronous
// 1-cycle-latency memory read port and compares each word with expected_word().
//   clk, reset_n   : clock, async active-low reset
//   start, abort   : begin a sweep from IDLE/DONE / cancel an active sweep
//   addr, wr_en    : memory read address, write enable (always 0)
//   rd_data        : memory read data, valid one cycle after addr is registered
//   busy, done     : sweep active / sweep completed (held until next start)
//   pass           : done with zero mismatches
//   err_count      : mismatches in the last/current sweep
//   first_err_addr : address of the first mismatch, 0 if none
module mem_verify_reader
    import mem_demo_pkg::*;
#(
    parameter int unsigned     ADDR_W = ADDR_W_DEF,
    parameter int unsigned     DATA_W = DATA_W_DEF,
    parameter int unsigned     BASE   = 0,
    parameter int unsigned     DEPTH  = 1024,
    parameter logic [DATA_W-1:0] SEED = '0
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic              abort,
    output logic [ADDR_W-1:0] addr,
    output logic              wr_en,
    input  logic [DATA_W-1:0] rd_data,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [ADDR_W:0]   err_count,
    output logic [ADDR_W-1:0] first_err_addr
);

    localparam logic [ADDR_W-1:0] BASE_A   = ADDR_W'(BASE);
    localparam logic [ADDR_W-1:0] LAST_CNT = ADDR_W'(DEPTH - 1);

    state_t            state, state_nx;
    logic [ADDR_W-1:0] cnt;
    logic              rd_valid;   // a read issued last cycle returns on rd_data now
    logic [ADDR_W-1:0] rd_addr;    // address of that read
    logic              start_ok;
    logic              cmp_valid;
    logic              mismatch;
    logic [DATA_W-1:0] exp_data;

    assign wr_en    = 1'b0;
    assign start_ok = (state == ST_IDLE || state == ST_DONE) && start && !abort;

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state logic
    always_comb begin
        state_nx = state;
        unique case (state)
            ST_IDLE, ST_DONE: if (start_ok) state_nx = ST_SCAN;
            ST_SCAN: begin
                if (abort)                 state_nx = ST_IDLE;
                else if (cnt == LAST_CNT)  state_nx = ST_DRAIN;
            end
            ST_DRAIN: begin
                // Last compare retires on the edge where rd_valid is still set.
                if (abort)                 state_nx = ST_IDLE;
                else if (!rd_valid)        state_nx = ST_DONE;
            end
            default:                       state_nx = ST_IDLE;
        endcase
    end

    // Outputs
    always_comb begin
        busy = (state == ST_SCAN) || (state == ST_DRAIN);
        done = (state == ST_DONE);
        pass = (state == ST_DONE) && (err_count == '0);
    end

    // Address counter and in-flight read tracking
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            addr     <= '0;
            cnt      <= '0;
            rd_valid <= 1'b0;
            rd_addr  <= '0;
        end else begin
            rd_valid <= (state == ST_SCAN) && !abort;
            rd_addr  <= addr;
            if (start_ok) begin
                addr <= BASE_A;
                cnt  <= '0;
            end else if (state == ST_SCAN && !abort && cnt != LAST_CNT) begin
                addr <= addr + ADDR_W'(1);   // natural wrap past the top address
                cnt  <= cnt + ADDR_W'(1);
            end
        end
    end

    assign exp_data  = DATA_W'(expected_word(32'(rd_addr), 32'(SEED)));
    assign mismatch  = (rd_data != exp_data);
    // An abort discards the compare that would otherwise retire on the same edge.
    assign cmp_valid = rd_valid && !abort;

    mem_err_tracker #(
        .ADDR_W(ADDR_W)
    ) u_tracker (
        .clk            (clk),
        .reset_n        (reset_n),
        .clear          (start_ok),
        .cmp_valid      (cmp_valid),
        .cmp_addr       (rd_addr),
        .mismatch       (mismatch),
        .err_count      (err_count),
        .first_err_addr (first_err_addr)
    );

endmodule

// File: tb/tb_mem_verify_reader.sv
module tb_mem_verify_reader;

    localparam int NDUT = 4;
    localparam int unsigned   BASES  [NDUT] = '{0, 0, 1022, 7};
    localparam int unsigned   DEPTHS [NDUT] = '{4, 16, 4, 1};
    localparam logic [15:0]   SEEDS  [NDUT] = '{16'h0000, 16'h0000, 16'h0000, 16'h5A5A};

    typedef struct {
        int dut;
        int err;
        int first;
        int pass;
        int done_edge;
    } exp_t;

    logic            clk = 1'b0;
    logic            reset_n;
    logic [NDUT-1:0] start, abort;
    logic [NDUT-1:0] wren_w, busy_w, done_w, pass_w;
    logic [9:0]      addr_w  [NDUT];
    logic [10:0]     errc_w  [NDUT];
    logic [9:0]      first_w [NDUT];
    logic [15:0]     rd_w    [NDUT];
    logic [15:0]     mem     [1024];
    logic [NDUT-1:0] done_prev = '0;

    int   checks = 0;
    int   errors = 0;
    int   edge_cnt = 0;
    exp_t exp_q[$];

    always #5 clk = ~clk;

    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    // Behavioural synchronous RAM, one read port per DUT over a shared array.
    always @(posedge clk) begin
        for (int d = 0; d < NDUT; d++) rd_w[d] <= mem[addr_w[d]];
    end

    for (genvar g = 0; g < NDUT; g++) begin : g_dut
        mem_verify_reader #(
            .ADDR_W (10),
            .DATA_W (16),
            .BASE   (BASES[g]),
            .DEPTH  (DEPTHS[g]),
            .SEED   (SEEDS[g])
        ) u_dut (
            .clk            (clk),
            .reset_n        (reset_n),
            .start          (start[g]),
            .abort          (abort[g]),
            .addr           (addr_w[g]),
            .wr_en          (wren_w[g]),
            .rd_data        (rd_w[g]),
            .busy           (busy_w[g]),
            .done           (done_w[g]),
            .pass           (pass_w[g]),
            .err_count      (errc_w[g]),
            .first_err_addr (first_w[g])
        );
    end

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: on each rising done, pop the scoreboard and compare the results.
    always @(negedge clk) begin
        for (int d = 0; d < NDUT; d++) begin
            if (done_w[d] && !done_prev[d]) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_done dut=%0d actual=1 expected=0", d);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("sb_dut",        d,                e.dut);
                    check("sb_err_count",  int'(errc_w[d]),  e.err);
                    check("sb_first_addr", int'(first_w[d]), e.first);
                    check("sb_pass",       int'(pass_w[d]),  e.pass);
                    check("sb_busy_off",   int'(busy_w[d]),  0);
                    check("sb_latency",    edge_cnt,         e.done_edge);
                end
            end
        end
        done_prev = done_w;
    end

    task automatic run_sweep(input int d, input int base, input int depth,
                             input int e_err, input int e_first);
        exp_t e;
        bit   seen;
        @(negedge clk);
        e.dut       = d;
        e.err       = e_err;
        e.first     = e_first;
        e.pass      = (e_err == 0) ? 1 : 0;
        e.done_edge = edge_cnt + 1 + depth + 2;
        exp_q.push_back(e);
        start[d] = 1'b1;
        for (int k = 0; k < depth; k++) begin
            @(posedge clk);
            #1;
            start[d] = 1'b0;
            check("scan_addr", int'(addr_w[d]), (base + k) % 1024);
            if (k == 0) check("scan_busy", int'(busy_w[d]), 1);
        end
        seen = 1'b0;
        for (int t = 0; t < 20 && !seen; t++) begin
            @(negedge clk);
            if (done_w[d]) seen = 1'b1;
        end
        if (!seen) begin
            checks++;
            errors++;
            $display("FAIL done_timeout dut=%0d actual=0 expected=1", d);
        end
        @(negedge clk);
    endtask

    initial begin
        reset_n = 1'b0;
        start   = '0;
        abort   = '0;
        for (int i = 0; i < 1024; i++) mem[i] = 16'(i);

        repeat (2) @(negedge clk);
        for (int d = 0; d < NDUT; d++) begin
            check("rst_addr",  int'(addr_w[d]),  0);
            check("rst_busy",  int'(busy_w[d]),  0);
            check("rst_done",  int'(done_w[d]),  0);
            check("rst_pass",  int'(pass_w[d]),  0);
            check("rst_err",   int'(errc_w[d]),  0);
            check("rst_first", int'(first_w[d]), 0);
            check("wr_en_low", int'(wren_w[d]),  0);
        end
        reset_n = 1'b1;

        // Clean sweep, single fault, multiple faults
        run_sweep(0, 0, 4, 0, 0);
        mem[2] = 16'hFFFF;
        run_sweep(0, 0, 4, 1, 2);
        mem[2] = 16'h0002;
        mem[5] = 16'hA5A5;
        mem[9] = 16'h0000;
        run_sweep(1, 0, 16, 2, 5);
        mem[5] = 16'h0005;
        mem[9] = 16'h0009;

        // Wrapped window, clean then with a fault on wrapped address 0
        run_sweep(2, 1022, 4, 0, 0);
        mem[0] = 16'h1234;
        run_sweep(2, 1022, 4, 1, 0);
        mem[0] = 16'h0000;

        // DEPTH=1 with nonzero seed: mem[7]=7 differs from 7^5A5A
        run_sweep(3, 7, 1, 1, 7);

        // Abort at SCAN cycle 3
        @(negedge clk);
        start[0] = 1'b1;
        @(posedge clk);
        #1 start[0] = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        abort[0] = 1'b1;
        @(posedge clk);
        #1 abort[0] = 1'b0;
        check("abort_busy", int'(busy_w[0]), 0);
        check("abort_done", int'(done_w[0]), 0);
        repeat (6) @(negedge clk);
        check("abort_stays_idle", int'(done_w[0]) + int'(busy_w[0]), 0);

        // start && abort together in IDLE
        @(negedge clk);
        start[0] = 1'b1;
        abort[0] = 1'b1;
        @(posedge clk);
        #1 start[0] = 1'b0;
        abort[0] = 1'b0;
        check("start_abort_busy", int'(busy_w[0]), 0);
        @(negedge clk);
        check("start_abort_busy2", int'(busy_w[0]), 0);

        // Async reset mid-SCAN, between edges
        @(negedge clk);
        start[2] = 1'b1;
        @(posedge clk);
        #1 start[2] = 1'b0;
        @(posedge clk);
        #1;
        check("pre_reset_addr", int'(addr_w[2]), 1023);
        #1 reset_n = 1'b0;
        #1;
        check("midrst_addr",  int'(addr_w[2]), 0);
        check("midrst_busy",  int'(busy_w[2]), 0);
        check("midrst_done",  int'(done_w[2]), 0);
        check("midrst_err",   int'(errc_w[2]), 0);
        @(negedge clk);
        reset_n = 1'b1;
        run_sweep(2, 1022, 4, 0, 0);

        repeat (2) @(negedge clk);
        check("sb_empty", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
